// File: rtl/scrambler_codec.sv
// Bit-serial self-synchronizing scrambler/descrambler, polynomial x^7+x^4+1.
// MODE=0 scrambles (TX). MODE=1 descrambles (RX).
// A burst of `length` bits starts when request is seen in IDLE.
// dataOut/ready are registered and lag the sampled dataIn by one cycle.
module scrambler_codec #(
    parameter int unsigned MODE  = 0,
    parameter logic [6:0]  SEED  = 7'h7F,
    parameter int unsigned LEN_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dataIn,
    input  logic [LEN_W-1:0] length,
    input  logic             request,
    output logic             dataOut,
    output logic             ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic             IS_RX   = (MODE != 0);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             data_out_q, data_out_d;
    logic             ready_q, ready_d;

    // The first bit of a burst is processed in IDLE, on the same edge that
    // reloads the register, so it must use SEED rather than the stale lfsr_q.
    logic [6:0] lfsr_cur;
    logic       out_bit;
    logic       shift_bit;

    assign lfsr_cur = (state_q == IDLE) ? SEED : lfsr_q;
    assign out_bit  = dataIn ^ lfsr_cur[6] ^ lfsr_cur[3];

    // Both ends shift the scrambled bit: TX shifts what it sends, RX what it
    // receives. This keeps the two registers in lockstep.
    assign shift_bit = IS_RX ? dataIn : out_bit;

    // Next-state, LFSR update, counter and registered-output values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        count_d    = count_q;
        data_out_d = 1'b0;
        ready_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (request) begin
                    if (length != '0) begin
                        data_out_d = out_bit;
                        ready_d    = 1'b1;
                        lfsr_d     = {lfsr_cur[5:0], shift_bit};
                        count_d    = length - LEN_ONE;
                        state_d    = (length > LEN_ONE) ? BUSY : DONE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            BUSY: begin
                data_out_d = out_bit;
                ready_d    = 1'b1;
                lfsr_d     = {lfsr_cur[5:0], shift_bit};
                count_d    = count_q - LEN_ONE;
                if (count_q == LEN_ONE) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Only a falling request rearms the FSM, so a held request
                // cannot start a second burst.
                if (!request) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            count_q    <= '0;
            data_out_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
        end
    end

    assign dataOut = data_out_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_scrambler_codec.sv
// Testbench for scrambler_codec.
// A TX instance feeds an RX instance (RX request = TX ready).
// A third TX instance has SEED=0.
// Expected streams come from the recurrence y[n] = x[n] ^ y[n-4] ^ y[n-7],
// with y[-1..-7] = SEED[0..6].
module tb_scrambler_codec;

    typedef bit bitq_t[$];

    localparam logic [6:0] SEED = 7'h7F;

    logic        clk;
    logic        reset;

    logic        tx_din, tx_req, tx_dout, tx_rdy;
    logic [11:0] tx_len;
    logic        rx_dout, rx_rdy;
    logic [11:0] rx_len;
    logic        z_din, z_req, z_dout, z_rdy;
    logic [11:0] z_len;

    int total = 0;
    int bad   = 0;

    scrambler_codec #(.MODE(0), .SEED(SEED), .LEN_W(12)) u_tx (
        .clk(clk), .reset(reset), .dataIn(tx_din), .length(tx_len),
        .request(tx_req), .dataOut(tx_dout), .ready(tx_rdy)
    );

    scrambler_codec #(.MODE(1), .SEED(SEED), .LEN_W(12)) u_rx (
        .clk(clk), .reset(reset), .dataIn(tx_dout), .length(rx_len),
        .request(tx_rdy), .dataOut(rx_dout), .ready(rx_rdy)
    );

    scrambler_codec #(.MODE(0), .SEED(7'h00), .LEN_W(12)) u_z (
        .clk(clk), .reset(reset), .dataIn(z_din), .length(z_len),
        .request(z_req), .dataOut(z_dout), .ready(z_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scrambled stream from the recurrence over the output history.
    function automatic bitq_t scramble(input logic [6:0] seed, input bitq_t x);
        bitq_t h;
        bitq_t y;
        for (int i = 6; i >= 0; i--) h.push_back(seed[i]);
        for (int n = 0; n < x.size(); n++) begin
            bit b;
            b = x[n] ^ h[h.size()-4] ^ h[h.size()-7];
            h.push_back(b);
            y.push_back(b);
        end
        return y;
    endfunction

    // Descrambled stream: x[n] = y[n] ^ y[n-4] ^ y[n-7].
    function automatic bitq_t descramble(input logic [6:0] seed, input bitq_t y);
        bitq_t h;
        bitq_t x;
        for (int i = 6; i >= 0; i--) h.push_back(seed[i]);
        for (int n = 0; n < y.size(); n++) begin
            x.push_back(y[n] ^ h[h.size()-4] ^ h[h.size()-7]);
            h.push_back(y[n]);
        end
        return x;
    endfunction

    // One TX->RX loopback burst, checked every cycle.
    // At index change_at, TX length is rewritten to new_len; RX length stays fixed.
    task automatic run_loop(input string tag, input bitq_t x, input int change_at,
                            input logic [11:0] new_len);
        bitq_t y;
        bitq_t xr;
        int len;
        int tx_cnt;
        int rx_cnt;
        len    = x.size();
        y      = scramble(SEED, x);
        xr     = descramble(SEED, y);
        tx_cnt = 0;
        rx_cnt = 0;
        tx_len = 12'(len);
        rx_len = 12'(len);
        tx_req = 1'b1;
        tx_din = x[0];
        for (int k = 0; k < len + 3; k++) begin
            @(posedge clk);
            #1;
            tx_req = 1'b0;
            if (tx_rdy) tx_cnt++;
            if (rx_rdy) rx_cnt++;
            check({tag, " tx_ready"}, 32'(tx_rdy), 32'(k < len));
            check({tag, " tx_data"}, 32'(tx_dout), (k < len) ? 32'(y[k]) : 32'd0);
            check({tag, " rx_ready"}, 32'(rx_rdy), 32'(k >= 1 && k <= len));
            check({tag, " rx_data"}, 32'(rx_dout), (k >= 1 && k <= len) ? 32'(x[k-1]) : 32'd0);
            if (k >= 1 && k <= len) check({tag, " model_roundtrip"}, 32'(rx_dout), 32'(xr[k-1]));
            tx_din = (k + 1 < len) ? x[k+1] : 1'($urandom_range(0, 1));
            if (k + 1 == change_at) tx_len = new_len;
        end
        check({tag, " tx_ready_count"}, 32'(tx_cnt), 32'(len));
        check({tag, " rx_ready_count"}, 32'(rx_cnt), 32'(len));
    endtask

    initial begin
        bitq_t x;
        bitq_t y;
        int cnt;

        // Reset state, observed while reset is asserted.
        reset  = 1'b0;
        tx_din = 1'b0; tx_req = 1'b0; tx_len = '0; rx_len = '0;
        z_din  = 1'b0; z_req  = 1'b0; z_len  = '0;
        #1;
        check("reset tx_data", 32'(tx_dout), 32'd0);
        check("reset tx_ready", 32'(tx_rdy), 32'd0);
        check("reset rx_data", 32'(rx_dout), 32'd0);
        check("reset rx_ready", 32'(rx_rdy), 32'd0);
        check("reset z_ready", 32'(z_rdy), 32'd0);
        #11;
        reset = 1'b1;

        // Directed loopback from the test plan.
        x = '{1, 0, 1, 1, 0, 0, 1, 1};
        run_loop("loop8", x, -1, 12'd0);

        // All-zero input through TX, compared against the known sequence.
        x = '{0, 0, 0, 0, 0, 0, 0, 0};
        y = '{0, 0, 0, 0, 1, 1, 1, 0};
        tx_len = 12'd8; rx_len = 12'd8; tx_req = 1'b1; tx_din = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            tx_req = 1'b0;
            check("zero8 tx_ready", 32'(tx_rdy), 32'(k < 8));
            check("zero8 tx_data", 32'(tx_dout), (k < 8) ? 32'(y[k]) : 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        // Single-bit burst boundary.
        x = '{1};
        run_loop("len1", x, -1, 12'd0);

        // SEED=0, 16 zero bits, held request does not retrigger.
        z_len = 12'd16; z_req = 1'b1; z_din = 1'b0;
        cnt = 0;
        for (int k = 0; k < 21; k++) begin
            @(posedge clk);
            #1;
            if (z_rdy) cnt++;
            check("seed0 ready", 32'(z_rdy), 32'(k < 16));
            check("seed0 data", 32'(z_dout), 32'd0);
        end
        check("seed0 ready_count", 32'(cnt), 32'd16);
        z_req = 1'b0;
        @(posedge clk);
        #1;
        check("seed0 rearm ready", 32'(z_rdy), 32'd0);
        z_req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (z_rdy) cnt++;
        end
        check("seed0 second ready_count", 32'(cnt), 32'd16);
        z_req = 1'b0;

        // length==0: no burst, sits in DONE until request falls.
        tx_req = 1'b1; tx_len = 12'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("len0 ready", 32'(tx_rdy), 32'd0);
        end
        tx_len = 12'd3;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("len0 held_in_done ready", 32'(tx_rdy), 32'd0);
        end
        tx_req = 1'b0;
        @(posedge clk);
        #1;
        x = '{1, 1, 0};
        run_loop("after_len0", x, -1, 12'd0);

        // Asynchronous reset after 5 of 12 bits.
        x = {};
        for (int i = 0; i < 12; i++) x.push_back(1'b0);
        y = scramble(SEED, x);
        tx_len = 12'd12; rx_len = 12'd12; tx_req = 1'b1; tx_din = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            tx_req = 1'b0;
        end
        check("midreset pre tx_ready", 32'(tx_rdy), 32'd1);
        check("midreset pre tx_data", 32'(tx_dout), 32'(y[4]));
        #2;
        reset = 1'b0;
        #1;
        check("midreset async tx_data", 32'(tx_dout), 32'd0);
        check("midreset async tx_ready", 32'(tx_rdy), 32'd0);
        check("midreset async rx_ready", 32'(rx_rdy), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        x = {};
        for (int i = 0; i < 12; i++) x.push_back(1'($urandom_range(0, 1)));
        run_loop("after_reset", x, -1, 12'd0);

        // Length rewritten from 10 to 3 mid-burst.
        x = {};
        for (int i = 0; i < 10; i++) x.push_back(1'($urandom_range(0, 1)));
        run_loop("len_change", x, 3, 12'd3);

        // Randomized loopback bursts.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(1, 24));
            x = {};
            for (int i = 0; i < len; i++) x.push_back(1'($urandom_range(0, 1)));
            run_loop("random", x, -1, 12'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
